// File: rtl/accum_ctrl.sv
// Job sequencer feeding one accum instance: walks rows x chunks, generates
// address/accumulate/last controls and stalls upstream on read-modify-write hazards.
module accum_ctrl #(
  parameter int DATAW = 32,
  parameter int DEPTH = 512,
  parameter int ADDRW = $clog2(DEPTH),
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_cfg_valid,
  output logic             o_cfg_ready,
  input  logic [ADDRW:0]   i_cfg_rows,
  input  logic [CNTW-1:0]  i_cfg_chunks,
  input  logic [ADDRW-1:0] i_cfg_base,
  output logic             o_cfg_err,
  input  logic             i_valid,
  input  logic [DATAW-1:0] i_data,
  output logic             o_ready,
  output logic             o_valid,
  output logic [DATAW-1:0] o_data,
  output logic [ADDRW-1:0] o_addr,
  output logic             o_accum,
  output logic             o_last,
  output logic             o_busy,
  output logic             o_done,
  output logic [1:0]       dbg_state
);

  // Handshakes: config is taken on i_cfg_valid && o_cfg_ready, a beat on
  // i_valid && o_ready; neither ready ever looks at its own valid.

  localparam int ROWW = ADDRW + 1;
  localparam logic [ROWW-1:0] DEPTH_R = ROWW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [ROWW-1:0]  rows_q;
  logic [CNTW-1:0]  chunks_q;
  logic [ADDRW-1:0] base_q;
  logic [ADDRW-1:0] row;
  logic [CNTW-1:0]  chunk;
  logic             p_valid;
  logic [ADDRW-1:0] p_addr;

  logic             cfg_bad;
  logic             cfg_zero;
  logic [ADDRW-1:0] cand_addr;
  logic             cand_accum;
  logic             hazard;
  logic             row_last;
  logic             chunk_last;
  logic             fire;

  assign cfg_bad    = i_cfg_rows > DEPTH_R;
  assign cfg_zero   = (i_cfg_rows == '0) || (i_cfg_chunks == '0);
  assign cand_addr  = base_q + row;
  assign cand_accum = chunk != '0;
  assign row_last   = {1'b0, row} == (rows_q - ROWW'(1));
  assign chunk_last = chunk == (chunks_q - CNTW'(1));

  // An accumulate beat must not reach the accumulator while an earlier write
  // to the same address is still inside its two-cycle read-modify-write window.
  assign hazard = cand_accum &&
                  ((o_valid && (o_addr == cand_addr)) ||
                   (p_valid && (p_addr == cand_addr)));

  assign o_ready   = (state == RUN) && !hazard;
  assign fire      = i_valid && o_ready;
  assign dbg_state = state;

  always_comb begin
    state_nxt   = state;
    o_cfg_ready = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (state)
      IDLE: begin
        o_cfg_ready = 1'b1;
        if (i_cfg_valid && !cfg_bad) begin
          state_nxt = cfg_zero ? DONE : RUN;
        end
      end
      RUN: begin
        o_busy = 1'b1;
        if (fire && row_last && chunk_last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        o_done    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rows_q    <= '0;
      chunks_q  <= '0;
      base_q    <= '0;
      row       <= '0;
      chunk     <= '0;
      o_cfg_err <= 1'b0;
    end else begin
      o_cfg_err <= (state == IDLE) && i_cfg_valid && cfg_bad;
      if ((state == IDLE) && i_cfg_valid && !cfg_bad) begin
        rows_q   <= i_cfg_rows;
        chunks_q <= i_cfg_chunks;
        base_q   <= i_cfg_base;
        row      <= '0;
        chunk    <= '0;
      end else if (fire) begin
        if (row_last) begin
          row   <= '0;
          chunk <= chunk + CNTW'(1);
        end else begin
          row <= row + ADDRW'(1);
        end
      end
    end
  end

  // Beat payload registers hold their last value when no beat is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_addr  <= '0;
      o_accum <= 1'b0;
      o_last  <= 1'b0;
      p_valid <= 1'b0;
      p_addr  <= '0;
    end else begin
      o_valid <= fire;
      p_valid <= o_valid;
      p_addr  <= o_addr;
      if (fire) begin
        o_data  <= i_data;
        o_addr  <= cand_addr;
        o_accum <= cand_accum;
        o_last  <= chunk_last;
      end
    end
  end

  a_done_single: assert property (@(posedge clk) disable iff (rst) o_done |=> !o_done);
  a_ready_in_run: assert property (@(posedge clk) disable iff (rst) o_ready |-> o_busy);

endmodule
